// File: rtl/led_game_pkg.sv
// Shared types and widths for the LED game blocks.
package led_game_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StOn
  } state_e;

  localparam int unsigned ProbWidth  = 7;
  localparam int unsigned LevelWidth = 4;
  localparam int unsigned TimerWidth = 16;
  localparam int unsigned RoundWidth = 8;

endpackage

// File: rtl/phase_timer.sv
// Tick counter for one phase: cleared by load, advanced by tick, flags the limit-th tick.
module phase_timer
  import led_game_pkg::*;
#(
  parameter int unsigned Width = TimerWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             tick,
  input  logic [Width-1:0] limit,
  output logic             terminal
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted during the cycle whose tick completes the phase.
  assign terminal = tick && (count_q == limit - Width'(1));

endmodule

// File: rtl/led_round_scheduler.sv
// Game round scheduler: alternates gap and lit windows, ramps level and probability per round.
module led_round_scheduler
  import led_game_pkg::*;
#(
  parameter int unsigned N_LEDS           = 8,
  parameter int unsigned ON_TICKS         = 1000,
  parameter int unsigned GAP_TICKS        = 250,
  parameter int unsigned ROUNDS_PER_LEVEL = 4,
  parameter int unsigned PROB_START       = 2,
  parameter int unsigned PROB_MAX         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick,
  input  logic                  hit,
  output logic [N_LEDS-1:0]     led_enable,
  output logic [ProbWidth-1:0]  probability,
  output logic [LevelWidth-1:0] level,
  output logic                  busy,
  output logic                  round_done
);

  state_e state_q, state_d;

  logic                  win_end;
  logic                  game_start;
  logic                  timer_load;
  logic                  timer_tick;
  logic                  terminal;
  logic [TimerWidth-1:0] limit;

  logic [RoundWidth-1:0] round_q, round_d;
  logic [LevelWidth-1:0] level_q, level_d;
  logic [ProbWidth-1:0]  prob_q, prob_d;
  logic [N_LEDS-1:0]     led_q;
  logic                  round_done_q;

  assign limit      = (state_q == StOn) ? TimerWidth'(ON_TICKS) : TimerWidth'(GAP_TICKS);
  assign timer_load = (state_d != state_q);
  assign timer_tick = tick && (state_q != StIdle);

  phase_timer #(
    .Width(TimerWidth)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .tick    (timer_tick),
    .limit   (limit),
    .terminal(terminal)
  );

  // Stop outranks everything; hit and the last tick both close a lit window.
  always_comb begin
    state_d = state_q;
    win_end = 1'b0;
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StGap;
        end
        StGap: begin
          if (terminal) state_d = StOn;
        end
        StOn: begin
          if (hit || terminal) begin
            state_d = StGap;
            win_end = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign game_start = (state_q == StIdle) && (state_d == StGap);

  always_comb begin
    round_d = round_q;
    level_d = level_q;
    prob_d  = prob_q;
    if (game_start) begin
      round_d = '0;
      level_d = '0;
      prob_d  = ProbWidth'(PROB_START);
    end else if (win_end) begin
      if (round_q == RoundWidth'(ROUNDS_PER_LEVEL - 1)) begin
        round_d = '0;
        if (level_q != {LevelWidth{1'b1}}) level_d = level_q + LevelWidth'(1);
        if (prob_q < ProbWidth'(PROB_MAX)) prob_d = prob_q + ProbWidth'(1);
      end else begin
        round_d = round_q + RoundWidth'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      round_q      <= '0;
      level_q      <= '0;
      prob_q       <= ProbWidth'(PROB_START);
      led_q        <= '0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      level_q      <= level_d;
      prob_q       <= prob_d;
      led_q        <= {N_LEDS{state_d == StOn}};
      round_done_q <= win_end;
    end
  end

  assign led_enable  = led_q;
  assign probability = prob_q;
  assign level       = level_q;
  assign busy        = (state_q != StIdle);
  assign round_done  = round_done_q;

endmodule

// File: tb/tb_led_round_scheduler.sv
// Randomised and directed checks of led_round_scheduler against a behavioural game model.
module tb_led_round_scheduler;

  localparam int ON     = 3;
  localparam int GAP    = 2;
  localparam int RPL    = 2;
  localparam int PSTART = 2;
  localparam int PMAX_A = 3;
  localparam int PMAX_B = 16;

  logic       clk, rst, start, stop, tick, hit;
  logic [7:0] led_a, led_b;
  logic [6:0] prob_a, prob_b;
  logic [3:0] lvl_a, lvl_b;
  logic       busy_a, busy_b, rd_a, rd_b;

  led_round_scheduler #(
    .N_LEDS(8), .ON_TICKS(ON), .GAP_TICKS(GAP), .ROUNDS_PER_LEVEL(RPL),
    .PROB_START(PSTART), .PROB_MAX(PMAX_A)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .tick(tick), .hit(hit),
    .led_enable(led_a), .probability(prob_a), .level(lvl_a), .busy(busy_a),
    .round_done(rd_a)
  );

  led_round_scheduler #(
    .N_LEDS(8), .ON_TICKS(ON), .GAP_TICKS(GAP), .ROUNDS_PER_LEVEL(RPL),
    .PROB_START(PSTART), .PROB_MAX(PMAX_B)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .tick(tick), .hit(hit),
    .led_enable(led_b), .probability(prob_b), .level(lvl_b), .busy(busy_b),
    .round_done(rd_b)
  );

  // mode: 0 idle, 1 gap, 2 lit
  typedef struct packed {
    int mode;
    int ticks;
    int rounds;
    int lvl;
    int prob;
    int rd;
  } mdl_t;

  mdl_t ma, mb;
  int   n_vec = 0;
  int   n_err = 0;
  bit   cmp_en = 0;

  function automatic mdl_t mreset();
    mdl_t m;
    m      = '0;
    m.prob = PSTART;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int pmax, bit st, bit sp, bit tk, bit ht);
    mdl_t n;
    n    = m;
    n.rd = 0;
    if (sp) begin
      n.mode  = 0;
      n.ticks = 0;
    end else if (m.mode == 0) begin
      if (st) begin
        n.mode = 1; n.ticks = 0; n.rounds = 0; n.lvl = 0; n.prob = PSTART;
      end
    end else if (m.mode == 1) begin
      if (tk) begin
        n.ticks = m.ticks + 1;
        if (n.ticks == GAP) begin
          n.mode  = 2;
          n.ticks = 0;
        end
      end
    end else begin
      if (ht || (tk && m.ticks + 1 == ON)) begin
        n.mode   = 1;
        n.ticks  = 0;
        n.rd     = 1;
        n.rounds = m.rounds + 1;
        if (n.rounds == RPL) begin
          n.rounds = 0;
          n.lvl    = (m.lvl < 15) ? m.lvl + 1 : 15;
          n.prob   = (m.prob < pmax) ? m.prob + 1 : m.prob;
        end
      end else if (tk) begin
        n.ticks = m.ticks + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, PMAX_A, start, stop, tick, hit);
      mb <= mstep(mb, PMAX_B, start, stop, tick, hit);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input string tag, input mdl_t m, input logic [7:0] led,
                          input logic [6:0] pr, input logic [3:0] lv, input logic bz,
                          input logic rd);
    chk({tag, ".led_enable"}, 32'(led), (m.mode == 2) ? 32'hFF : 32'h0);
    chk({tag, ".probability"}, 32'(pr), 32'(m.prob));
    chk({tag, ".level"}, 32'(lv), 32'(m.lvl));
    chk({tag, ".busy"}, 32'(bz), (m.mode != 0) ? 32'd1 : 32'd0);
    chk({tag, ".round_done"}, 32'(rd), 32'(m.rd));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst("a", ma, led_a, prob_a, lvl_a, busy_a, rd_a);
      cmp_inst("b", mb, led_b, prob_b, lvl_b, busy_b, rd_b);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    rst = 0; start = 0; stop = 0; tick = 0; hit = 0;
    #2 rst = 1;
    run(2);
    cmp_en = 1;
    chk("lit.rst_led", 32'(led_a), 32'h0);
    chk("lit.rst_prob", 32'(prob_a), 32'd2);
    chk("lit.rst_level", 32'(lvl_a), 32'd0);
    chk("lit.rst_busy", 32'(busy_a), 32'd0);
    chk("lit.rst_rd", 32'(rd_a), 32'd0);

    // One full round with tick every cycle.
    rst = 0; tick = 1; start = 1;
    cyc();
    chk("lit.start_busy", 32'(busy_a), 32'd1);
    chk("lit.start_led", 32'(led_a), 32'h0);
    start = 0;
    cyc();
    chk("lit.gap1_led", 32'(led_a), 32'h0);
    cyc();
    chk("lit.on1_led", 32'(led_a), 32'hFF);
    run(2);
    chk("lit.on3_led", 32'(led_a), 32'hFF);
    chk("lit.on3_rd", 32'(rd_a), 32'd0);
    cyc();
    chk("lit.off_led", 32'(led_a), 32'h0);
    chk("lit.off_rd", 32'(rd_a), 32'd1);
    chk("lit.off_level", 32'(lvl_a), 32'd0);
    cyc();
    chk("lit.rd_once", 32'(rd_a), 32'd0);
    run(4);
    chk("lit.r2_level", 32'(lvl_a), 32'd1);
    chk("lit.r2_prob_a", 32'(prob_a), 32'd3);
    chk("lit.r2_prob_b", 32'(prob_b), 32'd3);
    run(10);
    chk("lit.r4_level", 32'(lvl_a), 32'd2);
    chk("lit.r4_prob_sat", 32'(prob_a), 32'd3);
    chk("lit.r4_prob_b", 32'(prob_b), 32'd4);

    // Hit on the second lit cycle.
    run(2);
    chk("lit.hit_on", 32'(led_a), 32'hFF);
    cyc();
    hit = 1;
    cyc();
    chk("lit.hit_led", 32'(led_a), 32'h0);
    chk("lit.hit_rd", 32'(rd_a), 32'd1);

    // Start and hit during the gap are ignored.
    start = 1;
    cyc();
    chk("lit.gap_ign_led", 32'(led_a), 32'h0);
    chk("lit.gap_ign_busy", 32'(busy_a), 32'd1);
    hit = 0; start = 0;
    cyc();
    chk("lit.gap_ign_on", 32'(led_a), 32'hFF);
    run(3);
    chk("lit.hit_counted", 32'(lvl_a), 32'd3);
    chk("lit.hit_prob_b", 32'(prob_b), 32'd5);

    // Stop and start together while lit.
    run(2);
    stop = 1; start = 1;
    cyc();
    chk("lit.stop_busy", 32'(busy_a), 32'd0);
    chk("lit.stop_led", 32'(led_a), 32'h0);
    chk("lit.stop_rd", 32'(rd_a), 32'd0);
    stop = 0;
    cyc();
    chk("lit.restart_level", 32'(lvl_b), 32'd0);
    chk("lit.restart_prob", 32'(prob_b), 32'd2);
    start = 0;

    // Asynchronous reset while lit.
    run(2);
    chk("lit.pre_rst_led", 32'(led_a), 32'hFF);
    #1 rst = 1;
    #1;
    chk("lit.arst_led", 32'(led_a), 32'h0);
    chk("lit.arst_busy", 32'(busy_a), 32'd0);
    chk("lit.arst_prob", 32'(prob_b), 32'd2);
    chk("lit.arst_rd", 32'(rd_a), 32'd0);
    cyc();
    rst = 0;

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 63) == 0);
      tick  = $urandom_range(0, 1);
      hit   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) rst = 1;
      cyc();
      rst = 0;
    end

    // Long uninterrupted game to reach both saturation points.
    stop = 1; start = 0; hit = 0; tick = 1;
    cyc();
    stop = 0; start = 1;
    cyc();
    start = 0;
    run(200);
    chk("lit.sat_level", 32'(lvl_b), 32'd15);
    chk("lit.sat_prob_b", 32'(prob_b), 32'd16);
    chk("lit.sat_prob_a", 32'(prob_a), 32'd3);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
